// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: shared interrupt-controller state encoding and XAAU vector constants
package jtdsp16_pkg;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_ISR = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [15:0] IRQ_VECTOR = 16'd0;
  localparam logic [15:0] TRAP_VECTOR = 16'd1;
endpackage

// File: rtl/jtdsp16_irq_sync.sv
// jtdsp16_irq_sync: IRQ pin synchroniser with rising-edge or level request output
module jtdsp16_irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic rst,
  input  logic clk,
  input  logic irq_pin,
  output logic set_pend
);
  logic [SYNC_STAGES-1:0] s;
  logic prev;
  // free-running on every clk so short pulses between cen cycles are not lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
      prev <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], irq_pin};
      prev <= s[SYNC_STAGES-1];
    end
  end
  assign set_pend = EDGE_MODE ? s[SYNC_STAGES-1] & ~prev : s[SYNC_STAGES-1];
endmodule

// File: rtl/jtdsp16_irq_ctrl.sv
// jtdsp16_irq_ctrl: IRQ/trap sequencer driving XAAU vector forcing and PI shadowing
module jtdsp16_irq_ctrl
  import jtdsp16_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic rst,
  input  logic clk,
  input  logic cen,
  input  logic irq_pin,
  input  logic irq_en,
  input  logic no_int,
  input  logic pc_halt,
  input  logic iret_dec,
  input  logic trap_dec,
  output logic ext_irq,
  output logic icall,
  output logic shadow,
  output logic iack,
  output logic irq_pend
);
  logic [1:0] state;
  logic set_pend;
  logic in_run;
  jtdsp16_irq_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE(EDGE_MODE)
  ) u_sync (
    .rst(rst),
    .clk(clk),
    .irq_pin(irq_pin),
    .set_pend(set_pend)
  );
  assign in_run = state == ST_RUN;
  assign icall = cen & trap_dec & in_run;
  assign ext_irq = cen & in_run & irq_pend & irq_en & ~no_int & ~pc_halt & ~trap_dec;
  assign shadow = state != ST_ISR;
  assign iack = state == ST_ISR;
  // pending request: a new edge beats the clear so an edge landing on the accept cycle is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_pend <= 1'b0;
    else irq_pend <= EDGE_MODE ? set_pend | (irq_pend & ~ext_irq) : set_pend;
  end
  // RUN -> ISR on accept, ISR -> GUARD on ireturn, GUARD lets one instruction through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else if (cen)
      state <= in_run ? ((ext_irq | icall) ? ST_ISR : ST_RUN) :
               state == ST_ISR ? (iret_dec ? ST_GUARD : ST_ISR) : ST_RUN;
  end
endmodule

// File: tb/tb_jtdsp16_irq_ctrl.sv
// tb_jtdsp16_irq_ctrl: directed checks of IRQ sequencing with a small XAAU PC/PI model
module tb_jtdsp16_irq_ctrl;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b0, irq_pin = 1'b0, irq_en = 1'b1;
  logic no_int = 1'b0, pc_halt = 1'b0, iret_dec = 1'b0, trap_dec = 1'b0;
  logic ext_irq, icall, shadow, iack, irq_pend;
  logic [15:0] pc, pi;
  logic [15:0] pc_val = 16'h0000;
  logic pc_ld = 1'b0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  jtdsp16_irq_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
    .rst(rst), .clk(clk), .cen(cen), .irq_pin(irq_pin), .irq_en(irq_en),
    .no_int(no_int), .pc_halt(pc_halt), .iret_dec(iret_dec), .trap_dec(trap_dec),
    .ext_irq(ext_irq), .icall(icall), .shadow(shadow), .iack(iack), .irq_pend(irq_pend)
  );

  // XAAU stand-in: vectors on ext_irq/icall, returns through PI, PI follows PC+1 while shadowed
  always_ff @(posedge clk) begin
    if (pc_ld) pc <= pc_val;
    else if (cen) begin
      pc <= ext_irq ? 16'h0000 : icall ? 16'h0001 : iret_dec ? pi : pc_halt ? pc : pc + 16'd1;
      if (shadow) pi <= pc + 16'd1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cen = 1'b0;
    irq_pin = 1'b1;
    tick();
    irq_pin = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_shadow", shadow, 1);
    chk("rst_iack", iack, 0);
    chk("rst_pend", irq_pend, 0);
    chk("rst_ext", ext_irq, 0);
    chk("rst_icall", icall, 0);
    rst = 1'b0;
    tick();
    // one-clk pulse, sparse cen, PC=0x0123 interrupted
    cen = 1'b0;
    pc_val = 16'h0123;
    pc_ld = 1'b1;
    irq_pin = 1'b1;
    tick();
    pc_ld = 1'b0;
    irq_pin = 1'b0;
    tick();
    chk("pend_2clk", irq_pend, 0);
    tick();
    chk("pend_3clk", irq_pend, 1);
    chk("ext_cen0", ext_irq, 0);
    tick();
    cen = 1'b1;
    #1;
    chk("ext_fire", ext_irq, 1);
    chk("icall_idle", icall, 0);
    tick();
    cen = 1'b0;
    chk("isr_shadow", shadow, 0);
    chk("isr_iack", iack, 1);
    chk("isr_pend_clr", irq_pend, 0);
    chk("isr_pc", pc, 16'h0000);
    chk("isr_pi", pi, 16'h0124);
    cen = 1'b1;
    tick();
    chk("isr_pc_inc", pc, 16'h0001);
    chk("isr_pi_frozen", pi, 16'h0124);
    iret_dec = 1'b1;
    #1;
    chk("iret_ext", ext_irq, 0);
    tick();
    iret_dec = 1'b0;
    chk("iret_pc", pc, 16'h0124);
    chk("iret_shadow", shadow, 1);
    chk("iret_iack", iack, 0);
    tick();
    // no_int holds off acceptance
    pulse();
    no_int = 1'b1;
    cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("noint_hold", ext_irq, 0);
      tick();
    end
    no_int = 1'b0;
    #1;
    chk("noint_fire", ext_irq, 1);
    tick();
    chk("noint_iack", iack, 1);
    // second edge during ISR waits for GUARD
    pulse();
    chk("isr_pend_set", irq_pend, 1);
    cen = 1'b1;
    #1;
    chk("isr_no_nest", ext_irq, 0);
    tick();
    iret_dec = 1'b1;
    #1;
    chk("isr_iret_ext", ext_irq, 0);
    tick();
    iret_dec = 1'b0;
    #1;
    chk("guard_ext", ext_irq, 0);
    chk("guard_shadow", shadow, 1);
    tick();
    #1;
    chk("after_guard_ext", ext_irq, 1);
    tick();
    chk("nest_iack", iack, 1);
    chk("nest_pend_clr", irq_pend, 0);
    iret_dec = 1'b1;
    tick();
    iret_dec = 1'b0;
    tick();
    // trap beats a coincident IRQ
    pulse();
    trap_dec = 1'b1;
    cen = 1'b1;
    #1;
    chk("trap_icall", icall, 1);
    chk("trap_ext", ext_irq, 0);
    tick();
    chk("trap_pc", pc, 16'h0001);
    chk("trap_pend_kept", irq_pend, 1);
    chk("trap_shadow", shadow, 0);
    #1;
    chk("trap_in_isr", icall, 0);
    trap_dec = 1'b0;
    iret_dec = 1'b1;
    tick();
    iret_dec = 1'b0;
    #1;
    chk("trap_guard_ext", ext_irq, 0);
    tick();
    #1;
    chk("trap_then_irq", ext_irq, 1);
    tick();
    iret_dec = 1'b1;
    tick();
    iret_dec = 1'b0;
    tick();
    // irq_en gating, pc_halt, then reset mid-ISR
    pulse();
    irq_en = 1'b0;
    cen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("en0_hold", ext_irq, 0);
      tick();
    end
    chk("en0_pend", irq_pend, 1);
    irq_en = 1'b1;
    pc_halt = 1'b1;
    #1;
    chk("halt_hold", ext_irq, 0);
    pc_halt = 1'b0;
    #1;
    chk("en1_fire", ext_irq, 1);
    tick();
    chk("en1_pend_clr", irq_pend, 0);
    chk("en1_iack", iack, 1);
    #1;
    chk("en1_single", ext_irq, 0);
    rst = 1'b1;
    #1;
    chk("rst_isr_shadow", shadow, 1);
    chk("rst_isr_iack", iack, 0);
    chk("rst_isr_pend", irq_pend, 0);
    tick();
    rst = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
